clk_lock_monitor: RTL



---
 rtl/clk_lock_monitor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/clk_lock_monitor.sv
// Frequency lock monitor: counts FX_IN rising edges over back-to-back CLKIN gate
// windows and raises LOCKED after LOCK_WINDOWS consecutive in-range windows.
module clk_lock_monitor #(
    parameter int GATE_CYCLES  = 1024,
    parameter int CNT_W        = 16,
    parameter int EXP_MIN      = 500,
    parameter int EXP_MAX      = 524,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic             CLKIN,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             FX_IN,
    output logic [CNT_W-1:0] COUNT,
    output logic             COUNT_VALID,
    output logic             LOCKED,
    output logic [2:0]       STATUS
);

    // state   | meaning
    // IDLE    | counters cleared, LOCKED low, waiting for EN
    // MEASURE | gate windows running back to back, one COUNT_VALID per window

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam int RUN_W  = $clog2(LOCK_WINDOWS + 1);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(EXP_MAX);
    localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(LOCK_WINDOWS);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              fx_s1_q, fx_s2_q, fx_s3_q;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              locked_q, locked_d;
    logic [2:0]        status_q, status_d;

    logic              edge_w;
    logic [CNT_W-1:0]  edge_sum;
    logic              win_sat, win_low, win_high, win_good;
    logic [RUN_W-1:0]  run_inc;

    assign edge_w = fx_s2_q & ~fx_s3_q;

    always_comb begin
        edge_sum = (edge_cnt_q == CNT_MAX) ? CNT_MAX : edge_cnt_q + CNT_W'(edge_w);
        win_sat  = (edge_sum == CNT_MAX);
        win_low  = (edge_sum < MIN_C);
        win_high = (edge_sum > MAX_C);
        win_good = ~win_sat & ~win_low & ~win_high;
        run_inc  = (run_q == RUN_FULL) ? RUN_FULL : run_q + RUN_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        edge_cnt_d = edge_cnt_q;
        run_d      = run_q;
        count_d    = count_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        status_d   = status_q;

        case (state_q)
            ST_IDLE: begin
                gate_d     = '0;
                edge_cnt_d = '0;
                run_d      = '0;
                locked_d   = 1'b0;
                if (EN) begin
                    state_d = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                if (!EN) begin
                    // Partial window is dropped; COUNT and STATUS keep the last result.
                    state_d    = ST_IDLE;
                    gate_d     = '0;
                    edge_cnt_d = '0;
                    run_d      = '0;
                    locked_d   = 1'b0;
                end else if (gate_q == GATE_LAST) begin
                    // An edge on the closing cycle belongs to the closing window only.
                    gate_d     = '0;
                    edge_cnt_d = '0;
                    count_d    = edge_sum;
                    valid_d    = 1'b1;
                    status_d   = {win_high, win_low, win_sat};
                    if (win_good) begin
                        run_d    = run_inc;
                        locked_d = (run_inc == RUN_FULL);
                    end else begin
                        run_d    = '0;
                        locked_d = 1'b0;
                    end
                end else begin
                    gate_d     = gate_q + GATE_W'(1);
                    edge_cnt_d = edge_sum;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKIN) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            fx_s1_q    <= 1'b0;
            fx_s2_q    <= 1'b0;
            fx_s3_q    <= 1'b0;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            run_q      <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            status_q   <= 3'b000;
        end else begin
            state_q    <= state_d;
            fx_s1_q    <= FX_IN;
            fx_s2_q    <= fx_s1_q;
            fx_s3_q    <= fx_s2_q;
            gate_q     <= gate_d;
            edge_cnt_q <= edge_cnt_d;
            run_q      <= run_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            status_q   <= status_d;
        end
    end

    assign COUNT       = count_q;
    assign COUNT_VALID = valid_q;
    assign LOCKED      = locked_q;
    assign STATUS      = status_q;

endmodule
